// File: rtl/eth_parse_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : eth_parse_ctrl
//  Description : Frame-level sequencer for the Ethernet parser front end.
//                Gates AXI-Stream ready, pulses frame_start / parse_start,
//                holds the stream while the header parser runs, flags runt
//                frames and parser timeouts, and keeps saturating frame
//                statistics. Never touches tdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_parse_ctrl #(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_BYTES     = 18,
    parameter int PARSE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        beat_accept,
    output logic        frame_start,
    input  logic        header_valid,
    output logic        parse_start,
    input  logic        parse_done,
    output logic        runt_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] runt_cnt,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int HDR_BEATS      = (HDR_BYTES + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;

    localparam logic [4:0]  c_HDR_BEATS = 5'(HDR_BEATS);
    // Timeout fires on the PARSE_TIMEOUT-th cycle after parse_start; the
    // counter starts at zero on the first cycle with started set.
    localparam logic [15:0] c_TO_LAST   = 16'(PARSE_TIMEOUT - 1);
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_ARM     = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_PARSE   = 2'd2;
    localparam logic [1:0] c_ST_DRAIN   = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_beat_cnt;
    logic        r_last_seen;
    logic        r_started;
    logic [15:0] r_to_cnt;
    logic        r_runt_err;
    logic        r_timeout_err;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_runt_cnt;

    logic        w_tready;
    logic        w_beat_accept;
    logic        w_parse_start;
    logic [4:0]  w_beat_next;
    logic        w_hdr_complete;
    logic        w_done;
    logic        w_timeout;
    logic        w_runt;
    logic        w_frame_done;
    logic        w_timeout_hit;

    // ------------------------------------------------------------------------
    // State-decoded handshake and pulse outputs
    // ------------------------------------------------------------------------
    assign w_tready       = (r_state == c_ST_CAPTURE) || (r_state == c_ST_DRAIN);
    assign w_beat_accept  = s_axis_tvalid && w_tready;
    assign w_parse_start  = (r_state == c_ST_PARSE) && header_valid && !r_started;

    assign w_beat_next    = r_beat_cnt + 5'd1;
    assign w_hdr_complete = (w_beat_next == c_HDR_BEATS);

    // parse_done only counts once the parser has actually been kicked; a
    // done in the parse_start cycle itself is therefore ignored.
    assign w_done         = r_started && parse_done;
    assign w_timeout      = r_started && (r_to_cnt == c_TO_LAST);

    assign s_axis_tready  = w_tready;
    assign beat_accept    = w_beat_accept;
    assign frame_start    = (r_state == c_ST_ARM);
    assign busy           = (r_state != c_ST_ARM);
    assign parse_start    = w_parse_start;
    assign runt_err       = r_runt_err;
    assign timeout_err    = r_timeout_err;
    assign frame_cnt      = r_frame_cnt;
    assign runt_cnt       = r_runt_cnt;

    // Next-state and per-frame event decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_runt        = 1'b0;
        w_frame_done  = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            c_ST_ARM: begin
                // One cycle so the capture register can clear before beat 1.
                w_state_nxt = c_ST_CAPTURE;
            end
            c_ST_CAPTURE: begin
                if (w_beat_accept) begin
                    if (s_axis_tlast && (w_beat_next < c_HDR_BEATS)) begin
                        w_runt      = 1'b1;
                        w_state_nxt = c_ST_ARM;
                    end else if (w_hdr_complete) begin
                        w_state_nxt = c_ST_PARSE;
                    end
                end
            end
            c_ST_PARSE: begin
                // A done arriving in the timeout cycle wins over the timeout.
                if (w_done || w_timeout) begin
                    w_timeout_hit = !w_done;
                    if (r_last_seen) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = c_ST_ARM;
                    end else begin
                        w_state_nxt  = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (w_beat_accept && s_axis_tlast) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = c_ST_ARM;
                end
            end
            default: begin
                w_state_nxt = c_ST_ARM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Header beat counter and tlast capture on the header-completing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= 5'd0;
            r_last_seen <= 1'b0;
        end else if (r_state == c_ST_ARM) begin
            r_beat_cnt  <= 5'd0;
            r_last_seen <= 1'b0;
        end else if ((r_state == c_ST_CAPTURE) && w_beat_accept) begin
            r_beat_cnt <= w_beat_next;
            if (w_hdr_complete) begin
                r_last_seen <= s_axis_tlast;
            end
        end
    end

    // Parser handshake tracking and timeout counter; the counter only runs
    // after parse_start, so a header that never arrives never times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_to_cnt  <= 16'd0;
        end else if (r_state == c_ST_ARM) begin
            r_started <= 1'b0;
            r_to_cnt  <= 16'd0;
        end else if (r_state == c_ST_PARSE) begin
            if (w_parse_start) begin
                r_started <= 1'b1;
            end
            if (r_started) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_runt_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_runt_err    <= w_runt;
            r_timeout_err <= w_timeout_hit;
        end
    end

    // Saturating frame statistics; counters hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
            r_runt_cnt  <= 16'd0;
        end else begin
            if (w_frame_done && (r_frame_cnt != c_CNT_MAX)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_runt && (r_runt_cnt != c_CNT_MAX)) begin
                r_runt_cnt <= r_runt_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
